// File: rtl/block_check_arbiter.sv
// Round-robin front end for a shared begin/end checker: streams one requester's
// frame at a time into the checker and reports the verdict, length and owner per frame.
module block_check_arbiter #(
    parameter int IDLE_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       chk_clr,
    output logic       chk_en,
    output logic [7:0] chk_in,
    input  logic       chk_result,
    output logic       done_valid,
    output logic       done_id,
    output logic       done_result,
    output logic       done_err,
    output logic [7:0] done_len
);
    // state  | meaning
    // IDLE   | wait for a requester, latch round-robin grant
    // CLEAR  | one-cycle clear of the shared checker
    // STREAM | forward the granted requester's characters
    // DRAIN  | checker consumes the final character
    // REPORT | capture the verdict and pulse done_valid
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam int SW = $clog2(IDLE_LIMIT + 1);

    state_t        state;
    state_t        state_next;
    logic          grant;
    logic          grant_next;
    logic          last_grant;
    logic [7:0]    len_cnt;
    logic [SW-1:0] stall_cnt;
    logic          sel_valid;
    logic          sel_last;
    logic [7:0]    sel_char;
    logic          any_valid;
    logic          accept;
    logic          stall;
    logic          abort;

    assign sel_valid  = grant ? req1_valid : req0_valid;
    assign sel_last   = grant ? req1_last  : req0_last;
    assign sel_char   = grant ? req1_char  : req0_char;
    assign any_valid  = req0_valid || req1_valid;
    assign grant_next = (req0_valid && req1_valid) ? !last_grant : req1_valid;

    assign accept = (state == STREAM) && sel_valid;
    assign stall  = (state == STREAM) && !sel_valid;
    // Abort on the stall cycle that would bring the count up to IDLE_LIMIT.
    assign abort  = stall && (stall_cnt == SW'(IDLE_LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = CLEAR;
            CLEAR:   state_next = STREAM;
            STREAM: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && sel_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        chk_clr    = 1'b0;
        case (state)
            CLEAR:  chk_clr = 1'b1;
            STREAM: begin
                req0_ready = !grant;
                req1_ready = grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            len_cnt     <= 8'd0;
            stall_cnt   <= '0;
            chk_en      <= 1'b0;
            chk_in      <= 8'd0;
            done_valid  <= 1'b0;
            done_id     <= 1'b0;
            done_result <= 1'b0;
            done_err    <= 1'b0;
            done_len    <= 8'd0;
        end else begin
            chk_en     <= accept;
            done_valid <= 1'b0;

            if (accept) begin
                chk_in <= sel_char;
            end

            if (state == IDLE && any_valid) begin
                grant <= grant_next;
            end

            if (state == CLEAR) begin
                len_cnt <= 8'd0;
            end else if (accept && len_cnt != 8'hFF) begin
                len_cnt <= len_cnt + 8'd1;
            end

            if (!stall || abort) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            // The pointer moves only when a frame finishes, normally or by abort.
            if (state == REPORT) begin
                done_valid  <= 1'b1;
                done_id     <= grant;
                done_result <= chk_result;
                done_err    <= 1'b0;
                done_len    <= len_cnt;
                last_grant  <= grant;
            end else if (abort) begin
                done_valid  <= 1'b1;
                done_id     <= grant;
                done_result <= 1'b0;
                done_err    <= 1'b1;
                done_len    <= len_cnt;
                last_grant  <= grant;
            end
        end
    end
endmodule

// File: tb/tb_block_check_arbiter.sv
// Bench for block_check_arbiter: directed frames, a behavioural begin/end checker,
// and a scoreboard monitor comparing characters and per-frame reports.
module tb_block_check_arbiter;
    localparam int IDLE_LIMIT = 16;
    localparam logic [39:0] KW_BEGIN = "begin";
    localparam logic [23:0] KW_END   = "end";

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_char, req1_char;
    logic       req0_last, req1_last;
    logic       req0_ready, req1_ready;
    logic       chk_clr, chk_en;
    logic [7:0] chk_in;
    logic       chk_result;
    logic       done_valid, done_id, done_result, done_err;
    logic [7:0] done_len;

    typedef struct {
        logic       id;
        logic       result;
        logic       err;
        logic [7:0] len;
    } rep_t;

    rep_t       exp_q[$];
    logic [7:0] char_q[$];
    int         checks = 0;
    int         errors = 0;
    int         clr_seen = 0;

    always #5 clk = ~clk;

    block_check_arbiter #(.IDLE_LIMIT(IDLE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_char(req0_char), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_char(req1_char), .req1_last(req1_last), .req1_ready(req1_ready),
        .chk_clr(chk_clr), .chk_en(chk_en), .chk_in(chk_in), .chk_result(chk_result),
        .done_valid(done_valid), .done_id(done_id), .done_result(done_result),
        .done_err(done_err), .done_len(done_len)
    );

    // Shared checker stand-in: counts "begin" and word-initial "end".
    logic [31:0] hist;
    logic [39:0] win;
    int          depth;
    logic        neg;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
    endfunction

    assign win        = {hist, chk_in};
    assign chk_result = !neg && (depth == 0);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist  <= '0;
            depth <= 0;
            neg   <= 1'b0;
        end else if (chk_clr) begin
            hist  <= '0;
            depth <= 0;
            neg   <= 1'b0;
        end else if (chk_en) begin
            hist <= win[31:0];
            if (win == KW_BEGIN) begin
                depth <= depth + 1;
            end else if (win[23:0] == KW_END && !is_letter(win[31:24])) begin
                if (depth == 0) neg <= 1'b1;
                else depth <= depth - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [7:0] c;
        rep_t       e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                clr_seen = 0;
            end else begin
                if (chk_clr) clr_seen++;
                if (chk_en) begin
                    if (char_q.size() == 0) begin
                        check("chk_en_unexpected", {31'd0, chk_en}, 32'd0);
                    end else begin
                        c = char_q.pop_front();
                        check("chk_in", {24'd0, chk_in}, {24'd0, c});
                    end
                end
                if (done_valid) begin
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", {31'd0, done_valid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_id", {31'd0, done_id}, {31'd0, e.id});
                        check("done_result", {31'd0, done_result}, {31'd0, e.result});
                        check("done_err", {31'd0, done_err}, {31'd0, e.err});
                        check("done_len", {24'd0, done_len}, {24'd0, e.len});
                        check("clr_pulses", clr_seen, 32'd1);
                    end
                    clr_seen = 0;
                end
            end
        end
    endtask

    task automatic drive(input bit id, input logic v, input logic [7:0] c, input logic l);
        if (id) begin
            req1_valid = v; req1_char = c; req1_last = l;
        end else begin
            req0_valid = v; req0_char = c; req0_last = l;
        end
    endtask

    task automatic wait_ready(input bit id, output bit ok);
        int budget;
        budget = 0;
        ok = 1'b1;
        while (!(id ? req1_ready : req0_ready)) begin
            if (budget >= 2000) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout req%0d waited=%0d required=<2000", id, budget);
                ok = 1'b0;
                return;
            end
            budget++;
            @(negedge clk);
        end
    endtask

    task automatic send(input bit id, input string s, input bit mark_last, input int stall);
        bit ok;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            drive(id, 1'b1, s[i], mark_last && (i == s.len() - 1));
            wait_ready(id, ok);
            if (!ok) begin
                drive(id, 1'b0, 8'h00, 1'b0);
                return;
            end
            char_q.push_back(s[i]);
            if (stall > 0 && i < s.len() - 1) begin
                @(negedge clk);
                drive(id, 1'b0, 8'h00, 1'b0);
                repeat (stall - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        drive(id, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic expect_rep(input logic id, input logic result, input logic err, input logic [7:0] len);
        rep_t e;
        e.id = id; e.result = result; e.err = err; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
        check({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
        check({tag, "_chk_clr"}, {31'd0, chk_clr}, 32'd0);
        check({tag, "_chk_en"}, {31'd0, chk_en}, 32'd0);
        check({tag, "_chk_in"}, {24'd0, chk_in}, 32'd0);
        check({tag, "_done_valid"}, {31'd0, done_valid}, 32'd0);
        check({tag, "_done_id"}, {31'd0, done_id}, 32'd0);
        check({tag, "_done_result"}, {31'd0, done_result}, 32'd0);
        check({tag, "_done_err"}, {31'd0, done_err}, 32'd0);
        check({tag, "_done_len"}, {24'd0, done_len}, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        string long_s;
        bit    ok;

        reset = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        fork monitor(); join_none
        @(negedge clk);
        check_zero("rst");
        @(negedge clk);
        reset = 1'b1;

        // "begin end" from req0, with report latency measured from the last accept
        expect_rep(0, 1, 0, 8'd9);
        send(0, "begin end", 1, 0);
        check("lat_k1", {31'd0, done_valid}, 32'd0);
        @(negedge clk);
        check("lat_k2", {31'd0, done_valid}, 32'd0);
        @(negedge clk);
        check("lat_k3", {31'd0, done_valid}, 32'd1);
        repeat (10) @(negedge clk);

        // Both requesters valid straight after reset: req0 first
        apply_reset();
        expect_rep(0, 0, 0, 8'd5);
        expect_rep(1, 0, 0, 8'd5);
        fork
            send(0, "begin", 1, 0);
            send(1, "begin", 1, 0);
        join
        repeat (10) @(negedge clk);

        // req1 "end" with three-cycle stalls; fields hold after the pulse
        expect_rep(1, 0, 0, 8'd3);
        send(1, "end", 1, 3);
        repeat (10) @(negedge clk);
        check("hold_valid", {31'd0, done_valid}, 32'd0);
        check("hold_id", {31'd0, done_id}, 32'd1);
        check("hold_len", {24'd0, done_len}, 32'd3);

        // req0 stalls out after "be"; req1 waits and is served next
        expect_rep(0, 0, 1, 8'd2);
        expect_rep(1, 1, 0, 8'd9);
        fork
            send(0, "be", 0, 0);
            begin
                repeat (4) @(negedge clk);
                send(1, "begin end", 1, 0);
            end
        join
        repeat (10) @(negedge clk);

        // 15 stall cycles is one short of the abort threshold
        expect_rep(0, 1, 0, 8'd2);
        send(0, "ab", 1, IDLE_LIMIT - 1);
        repeat (10) @(negedge clk);

        // 260 characters: length saturates
        long_s = "";
        for (int i = 0; i < 260; i++) long_s = {long_s, "a"};
        expect_rep(1, 1, 0, 8'd255);
        send(1, long_s, 1, 0);
        repeat (10) @(negedge clk);

        // Reset lands during req0's third character
        @(negedge clk);
        drive(0, 1'b1, "b", 1'b0);
        wait_ready(0, ok);
        char_q.push_back("b");
        @(negedge clk);
        drive(0, 1'b1, "e", 1'b0);
        char_q.push_back("e");
        @(negedge clk);
        drive(0, 1'b1, "g", 1'b0);
        #2 reset = 1'b0;
        #1 check_zero("midrst");
        repeat (3) @(negedge clk);
        check("midrst_no_done", {31'd0, done_valid}, 32'd0);
        drive(0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        expect_rep(0, 1, 0, 8'd1);
        send(0, "a", 1, 0);
        repeat (10) @(negedge clk);

        // Back-to-back frames from both requesters alternate grants
        apply_reset();
        expect_rep(0, 1, 0, 8'd2);
        expect_rep(1, 1, 0, 8'd1);
        expect_rep(0, 1, 0, 8'd1);
        expect_rep(1, 1, 0, 8'd1);
        fork
            begin
                send(0, "ab", 1, 0);
                send(0, "c", 1, 0);
            end
            begin
                send(1, "x", 1, 0);
                send(1, "y", 1, 0);
            end
        join
        repeat (20) @(negedge clk);

        check("reports_left", exp_q.size(), 32'd0);
        check("chars_left", char_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/block_check_arbiter.md
BLOCK_CHECK_ARBITER -- requirements
Module: block_check_arbiter

Interface
REQ-001 SHALL have parameter IDLE_LIMIT, default 16; stall cycles tolerated mid-frame before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester has a character.
REQ-005 SHALL have ports req0_char/req1_char  input  8 each  ASCII character.
REQ-006 SHALL have ports req0_last/req1_last  input  1 each  character is the final one of a frame.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1 each  arbiter accepts the character this cycle.
REQ-008 SHALL have port chk_clr  output  1  synchronous clear to the shared checker.
REQ-009 SHALL have port chk_en  output  1  checker consumes chk_in at the next edge.
REQ-010 SHALL have port chk_in  output  8  character to the checker.
REQ-011 SHALL have port chk_result  input  1  checker verdict, 1 = begin/end balanced.
REQ-012 SHALL have ports done_valid (1), done_id (1), done_result (1), done_err (1), done_len (8)  outputs  per-frame report.

Function
REQ-013 SHALL implement states IDLE, CLEAR, STREAM, DRAIN, REPORT.
REQ-014 IDLE: if any req*_valid, SHALL grant one requester and go to CLEAR at the next edge; otherwise stay.
REQ-015 Arbitration SHALL be round-robin per frame: both valid -> grant the requester not granted last; first grant after reset goes to req0.
REQ-016 CLEAR: chk_clr=1 for exactly one cycle, then STREAM.
REQ-017 STREAM: only the granted ready=1, other ready=0; in all other states both ready=0.
REQ-018 A character is accepted when valid&&ready at an edge; that edge SHALL register chk_in=char and chk_en=1 for the following cycle only.
REQ-019 chk_en SHALL be 0 on every cycle with no accepted character, so stalls never inject characters.
REQ-020 done_len SHALL count accepted characters in the frame, saturating at 255.
REQ-021 An accepted character with last=1 SHALL move STREAM -> DRAIN; DRAIN -> REPORT after one cycle, so the checker has consumed the last character.
REQ-022 REPORT: at the next edge SHALL register done_result=chk_result, done_err=0, done_id=grant, done_len, and done_valid=1; then return to IDLE.
REQ-023 done_valid SHALL be a one-cycle pulse; done_* fields SHALL hold until the next report.
REQ-024 Latency: last accepted at edge k -> done_valid high in the cycle after edge k+2.
REQ-025 Stall counter: in STREAM, consecutive cycles with granted valid=0; cleared on accept.
REQ-026 Stall counter reaching IDLE_LIMIT SHALL abort: done_valid=1, done_err=1, done_result=0, current done_len, then IDLE.
REQ-027 The non-granted requester SHALL never be accepted mid-frame, even if it asserts valid or last.
REQ-028 A frame whose first character has last=1 SHALL be legal: done_len=1.
REQ-029 Grant pointer SHALL update at frame end (normal or abort), not at grant.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE, ready=0, chk_clr=0, chk_en=0, chk_in=0, done_valid=0, done_id=0, done_result=0, done_err=0, done_len=0, stall counter=0, and pointer=req1-last-granted.
REQ-031 Reset asserted mid-frame SHALL discard the frame with no report; the next frame begins with CLEAR.

Verification
REQ-032 req0 sends "begin end" (9 chars, last on 'd'), req1 idle -> CLEAR pulse, 9 chk_en pulses, done_valid with id=0, result=1, err=0, len=9.
REQ-033 Both valid in IDLE after reset, each sends "begin" -> req0 served first (result=0, len=5), then req1 (id=1, result=0, len=5); no interleaving on chk_in.
REQ-034 req1 sends "end", stalling 3 cycles between chars -> chk_en stays 0 during stalls; done_result=0, len=3, err=0.
REQ-035 req0 sends "be" then holds valid=0 for 16 cycles -> done_valid with err=1, result=0, len=2; arbiter returns to IDLE and serves req1 next.
REQ-036 Reset asserted during req0's third character -> all outputs zero at once, no done_valid; a following single-char frame "a" with last=1 -> len=1, result=1.
REQ-037 Back-to-back requester 0 frames while req1 is continuously valid -> grants alternate 0,1,0.
